// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O responder: switch input (synchronize, debounce, sticky rising edges),
// LED output register and a free-running cycle counter, in a 16-byte window at BASE_ADDR.
module mmio_io_ctrl #(
  parameter logic [31:0] BASE_ADDR       = 32'hFFFF_FF00,
  parameter int          SW_WIDTH        = 8,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic                cpuclk,
  input  logic                rst,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  input  logic                we,
  input  logic                re,
  input  logic [SW_WIDTH-1:0] switches,
  output logic                hit,
  output logic [31:0]         rdata,
  output logic [31:0]         led_out,
  output logic                sw_event
);

  localparam logic [1:0] OFF_SW    = 2'd0;
  localparam logic [1:0] OFF_LED   = 2'd1;
  localparam logic [1:0] OFF_EDGE  = 2'd2;
  localparam logic [1:0] OFF_CYCLE = 2'd3;

  logic [SW_WIDTH-1:0] r_sync1;
  logic [SW_WIDTH-1:0] r_sync2;
  logic [15:0]         r_cnt;
  logic [SW_WIDTH-1:0] r_sw_stable;
  logic [SW_WIDTH-1:0] r_sw_edge;
  logic [31:0]         r_cycle;
  logic [31:0]         r_led;
  logic [31:0]         r_rdata;

  logic [1:0]          w_off;
  logic                w_wr;
  logic                w_cnt_full;
  logic [SW_WIDTH-1:0] w_stable_nxt;
  logic [SW_WIDTH-1:0] w_rise;
  logic [SW_WIDTH-1:0] w_w1c;
  logic [31:0]         w_sw_ext;
  logic [31:0]         w_edge_ext;
  logic [31:0]         w_rd_mux;
  logic                w_unused;

  assign hit        = (addr[31:4] == BASE_ADDR[31:4]);
  assign w_off      = addr[3:2];
  assign w_wr       = we & hit;
  assign w_cnt_full = !(r_cnt < (DEBOUNCE_CYCLES - 16'd1));
  assign w_unused   = &{1'b0, addr[1:0]};

  // sw_sync is r_sync2; r_sync1 is the value it takes next, so a mismatch means it changes this edge.
  always_comb begin
    w_stable_nxt = r_sw_stable;
    if ((r_sync1 == r_sync2) && w_cnt_full)
      w_stable_nxt = r_sync2;
  end

  // Edges are taken against the incoming stable value so the set lands on the same edge.
  assign w_rise = w_stable_nxt & ~r_sw_stable;
  assign w_w1c  = (w_wr && (w_off == OFF_EDGE)) ? wdata[SW_WIDTH-1:0] : '0;

  always_comb begin
    w_sw_ext                 = '0;
    w_sw_ext[SW_WIDTH-1:0]   = r_sw_stable;
    w_edge_ext               = '0;
    w_edge_ext[SW_WIDTH-1:0] = r_sw_edge;
    case (w_off)
      OFF_SW:   w_rd_mux = w_sw_ext;
      OFF_LED:  w_rd_mux = r_led;
      OFF_EDGE: w_rd_mux = w_edge_ext;
      default:  w_rd_mux = r_cycle;
    endcase
  end

  always_ff @(posedge cpuclk) begin
    if (rst) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_cnt       <= '0;
      r_sw_stable <= '0;
      r_sw_edge   <= '0;
      r_cycle     <= '0;
      r_led       <= '0;
      r_rdata     <= '0;
    end else begin
      r_sync1 <= switches;
      r_sync2 <= r_sync1;
      if (r_sync1 != r_sync2)
        r_cnt <= '0;
      else if (!w_cnt_full)
        r_cnt <= r_cnt + 16'd1;
      r_sw_stable <= w_stable_nxt;
      r_sw_edge   <= (r_sw_edge & ~w_w1c) | w_rise;
      r_cycle     <= (w_wr && (w_off == OFF_CYCLE)) ? 32'd0 : r_cycle + 32'd1;
      if (w_wr && (w_off == OFF_LED))
        r_led <= wdata;
      // Read mux sees pre-write register values, so a same-offset re&we returns the old value.
      if (re)
        r_rdata <= hit ? w_rd_mux : 32'd0;
    end
  end

  assign rdata    = r_rdata;
  assign led_out  = r_led;
  assign sw_event = |r_sw_edge;

endmodule
